// File: rtl/pedometer_ctrl.sv
// Pedometer command controller: arbitrates between step-count samples and
// buffered weight writes, pairing writes into dual updates where possible.
module pedometer_ctrl #(
    parameter int PAIR_WAIT     = 2,
    parameter int MAX_UPD_BURST = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       smp_valid,
    input  logic [7:0] smp_a,
    input  logic [7:0] smp_b,
    output logic       smp_ready,
    input  logic       wr_valid,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       countSteps,
    output logic       updateWeight,
    output logic       dualUpdateWeights,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [2:0] Addr1,
    output logic [2:0] Addr2,
    output logic [7:0] Data1,
    output logic [7:0] Data2,
    output logic       busy,
    output logic [15:0] cnt_issued
);

    localparam int WAIT_W  = (PAIR_WAIT < 1) ? 1 : $clog2(PAIR_WAIT + 1);
    localparam int BURST_W = (MAX_UPD_BURST < 1) ? 1 : $clog2(MAX_UPD_BURST + 1);
    localparam logic [WAIT_W-1:0]  WAIT_INIT = WAIT_W'(PAIR_WAIT);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_UPD_BURST);

    typedef enum logic [1:0] {
        ACT_NOP = 2'd0,
        ACT_CNT = 2'd1,
        ACT_UPD = 2'd2
    } action_e;

    // Write holding buffer: slot0 is the older entry, slot1 the newer.
    logic [1:0]         count_q, count_d;
    logic [2:0]         addr0_q, addr0_d, addr1_q, addr1_d;
    logic [7:0]         data0_q, data0_d, data1_q, data1_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    // Registered command/operand outputs.
    logic        cs_q, cs_d, uw_q, uw_d, du_q, du_d;
    logic [7:0]  a_q, a_d, b_q, b_d, d1_q, d1_d, d2_q, d2_d;
    logic [2:0]  ad1_q, ad1_d, ad2_q, ad2_d;
    logic        busy_q, busy_d;
    logic [15:0] cnt_q, cnt_d;

    logic    upd_due;
    logic    wr_acc;
    action_e act;

    // Pick this edge's single action and derive the handshakes from it.
    always_comb begin
        upd_due = (count_q == 2'd2) || ((count_q == 2'd1) && (wait_q == '0));
        act     = ACT_NOP;
        if (upd_due && !((burst_q == BURST_MAX) && smp_valid)) begin
            act = ACT_UPD;
        end else if (smp_valid) begin
            act = ACT_CNT;
        end
        // Handshakes are forced low while reset is held, whatever the inputs.
        smp_ready = reset && (act == ACT_CNT);
        wr_ready  = reset && ((count_q != 2'd2) || (act == ACT_UPD) || (wr_addr == addr1_q));
        wr_acc    = wr_valid && wr_ready;
    end

    // Next-state for the buffer, burst limiter, counters and output registers.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        count_d = count_q;
        addr0_d = addr0_q;
        data0_d = data0_q;
        addr1_d = addr1_q;
        data1_d = data1_q;
        wait_d  = wait_q;
        burst_d = burst_q;
        cs_d    = 1'b0;
        uw_d    = 1'b0;
        du_d    = 1'b0;
        a_d     = '0;
        b_d     = '0;
        ad1_d   = '0;
        d1_d    = '0;
        ad2_d   = '0;
        d2_d    = '0;
        cnt_d   = cnt_q;

        unique case (act)
            ACT_CNT: begin
                cs_d = 1'b1;
                a_d  = smp_a;
                b_d  = smp_b;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end
            ACT_UPD: begin
                uw_d  = 1'b1;
                ad1_d = addr0_q;
                d1_d  = data0_q;
                if (count_q == 2'd2) begin
                    du_d  = 1'b1;
                    ad2_d = addr1_q;
                    d2_d  = data1_q;
                end
            end
            default: ;
        endcase

        // Consecutive updates are capped so a waiting sample is not starved.
        if (act == ACT_UPD) begin
            burst_d = (burst_q == BURST_MAX) ? BURST_MAX : burst_q + 1'b1;
        end else if ((act == ACT_CNT) || !upd_due) begin
            burst_d = '0;
        end

        if (act == ACT_UPD) begin
            // Buffer drains; a write arriving now becomes the new slot0.
            count_d = 2'd0;
            wait_d  = '0;
            if (wr_acc) begin
                addr0_d = wr_addr;
                data0_d = wr_data;
                count_d = 2'd1;
                wait_d  = WAIT_INIT;
            end
        end else begin
            case (count_q)
                2'd0: begin
                    if (wr_acc) begin
                        addr0_d = wr_addr;
                        data0_d = wr_data;
                        count_d = 2'd1;
                        wait_d  = WAIT_INIT;
                    end
                end
                2'd1: begin
                    if (wait_q != '0) wait_d = wait_q - 1'b1;
                    if (wr_acc) begin
                        // Same address merges without restarting the pairing wait.
                        if (wr_addr == addr0_q) begin
                            data0_d = wr_data;
                        end else begin
                            addr1_d = wr_addr;
                            data1_d = wr_data;
                            count_d = 2'd2;
                        end
                    end
                end
                default: begin
                    // Full buffer only accepts a merge into slot1.
                    if (wr_acc) data1_d = wr_data;
                end
            endcase
        end

        busy_d = (count_d != 2'd0);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            addr0_q <= '0;
            data0_q <= '0;
            addr1_q <= '0;
            data1_q <= '0;
            wait_q  <= '0;
            burst_q <= '0;
            cs_q    <= 1'b0;
            uw_q    <= 1'b0;
            du_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ad1_q   <= '0;
            d1_q    <= '0;
            ad2_q   <= '0;
            d2_q    <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            count_q <= count_d;
            addr0_q <= addr0_d;
            data0_q <= data0_d;
            addr1_q <= addr1_d;
            data1_q <= data1_d;
            wait_q  <= wait_d;
            burst_q <= burst_d;
            cs_q    <= cs_d;
            uw_q    <= uw_d;
            du_q    <= du_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ad1_q   <= ad1_d;
            d1_q    <= d1_d;
            ad2_q   <= ad2_d;
            d2_q    <= d2_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign countSteps        = cs_q;
    assign updateWeight      = uw_q;
    assign dualUpdateWeights = du_q;
    assign A                 = a_q;
    assign B                 = b_q;
    assign Addr1             = ad1_q;
    assign Data1             = d1_q;
    assign Addr2             = ad2_q;
    assign Data2             = d2_q;
    assign busy              = busy_q;
    assign cnt_issued        = cnt_q;

endmodule

// File: tb/tb_pedometer_ctrl.sv
// Self-checking bench for pedometer_ctrl: cycle scoreboard on the default
// instance plus directed scenarios, and a PAIR_WAIT=0 instance for bursts.
module tb_pedometer_ctrl;

    localparam int PW = 2;
    localparam int MB = 3;

    typedef struct packed {
        logic        cs;
        logic        uw;
        logic        du;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  ad1;
        logic [7:0]  d1;
        logic [2:0]  ad2;
        logic [7:0]  d2;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        smp_valid;
    logic [7:0]  smp_a, smp_b;
    logic        wr_valid;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;

    logic        smp_ready, wr_ready, countSteps, updateWeight, dualUpdateWeights, busy;
    logic [7:0]  A, B, Data1, Data2;
    logic [2:0]  Addr1, Addr2;
    logic [15:0] cnt_issued;

    logic        u2_smp_ready, u2_wr_ready, u2_cs, u2_uw, u2_du, u2_busy;
    logic [7:0]  u2_a, u2_b, u2_d1, u2_d2;
    logic [2:0]  u2_ad1, u2_ad2;
    logic [15:0] u2_cnt;

    int n_vec = 0;
    int n_err = 0;

    exp_t exp_q[$];

    // Reference model state (default parameters).
    int         m_count, m_wait, m_burst, m_cnt;
    logic [2:0] m_a0, m_a1;
    logic [7:0] m_d0, m_d1;

    pedometer_ctrl #(.PAIR_WAIT(PW), .MAX_UPD_BURST(MB)) u_dut (
        .clk(clk), .reset(reset),
        .smp_valid(smp_valid), .smp_a(smp_a), .smp_b(smp_b), .smp_ready(smp_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .countSteps(countSteps), .updateWeight(updateWeight), .dualUpdateWeights(dualUpdateWeights),
        .A(A), .B(B), .Addr1(Addr1), .Addr2(Addr2), .Data1(Data1), .Data2(Data2),
        .busy(busy), .cnt_issued(cnt_issued)
    );

    pedometer_ctrl #(.PAIR_WAIT(0), .MAX_UPD_BURST(MB)) u_dut_pw0 (
        .clk(clk), .reset(reset),
        .smp_valid(smp_valid), .smp_a(smp_a), .smp_b(smp_b), .smp_ready(u2_smp_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(u2_wr_ready),
        .countSteps(u2_cs), .updateWeight(u2_uw), .dualUpdateWeights(u2_du),
        .A(u2_a), .B(u2_b), .Addr1(u2_ad1), .Addr2(u2_ad2), .Data1(u2_d1), .Data2(u2_d2),
        .busy(u2_busy), .cnt_issued(u2_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t observe1();
        exp_t o;
        o.cs = countSteps; o.uw = updateWeight; o.du = dualUpdateWeights;
        o.a = A; o.b = B; o.ad1 = Addr1; o.d1 = Data1; o.ad2 = Addr2; o.d2 = Data2;
        o.busy = busy; o.cnt = cnt_issued;
        return o;
    endfunction

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic sb_check();
        exp_t e, o;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        o = observe1();
        n_vec++;
        if (o !== e) begin
            n_err++;
            $display("FAIL scoreboard t=%0t got=%h expected=%h", $time, o, e);
        end
    endtask

    // One clock: check the previous cycle, drive, check handshakes, predict.
    task automatic step(input logic sv, input logic [7:0] sa, input logic [7:0] sb,
                        input logic wv, input logic [2:0] wa, input logic [7:0] wd);
        exp_t e;
        logic due, upd, cs, ewr, acc;
        sb_check();
        smp_valid = sv; smp_a = sa; smp_b = sb;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        #1;
        due = (m_count == 2) || (m_count == 1 && m_wait == 0);
        upd = due && !(m_burst == MB && sv);
        cs  = !upd && sv;
        ewr = (m_count < 2) || upd || (wa == m_a1);
        acc = wv && ewr;
        n_vec++;
        if ({smp_ready, wr_ready} !== {cs, ewr}) begin
            n_err++;
            $display("FAIL ready t=%0t got smp/wr=%b%b expected=%b%b", $time, smp_ready, wr_ready, cs, ewr);
        end
        e = '0;
        if (cs) begin
            e.cs = 1'b1; e.a = sa; e.b = sb;
            if (m_cnt < 65535) m_cnt++;
        end
        if (upd) begin
            e.uw = 1'b1; e.ad1 = m_a0; e.d1 = m_d0;
            if (m_count == 2) begin
                e.du = 1'b1; e.ad2 = m_a1; e.d2 = m_d1;
            end
        end
        if (upd) m_burst = (m_burst < MB) ? m_burst + 1 : MB;
        else if (cs || !due) m_burst = 0;
        if (upd) begin
            m_count = 0; m_wait = 0;
            if (acc) begin m_a0 = wa; m_d0 = wd; m_count = 1; m_wait = PW; end
        end else if (m_count == 0) begin
            if (acc) begin m_a0 = wa; m_d0 = wd; m_count = 1; m_wait = PW; end
        end else if (m_count == 1) begin
            if (m_wait > 0) m_wait--;
            if (acc) begin
                if (wa == m_a0) m_d0 = wd;
                else begin m_a1 = wa; m_d1 = wd; m_count = 2; end
            end
        end else if (acc) begin
            m_d1 = wd;
        end
        e.busy = (m_count != 0);
        e.cnt  = 16'(m_cnt);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 8'd0, 8'd0, 1'b0, 3'd0, 8'd0);
    endtask

    // Hold reset with live traffic, check everything is quiet, then release.
    task automatic do_reset();
        sb_check();
        reset = 1'b0;
        smp_valid = 1'b1; smp_a = 8'hAA; smp_b = 8'h55;
        wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 8'hC3;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (observe1() !== '0 || smp_ready !== 1'b0 || wr_ready !== 1'b0 ||
                {u2_cs, u2_uw, u2_busy} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_state t=%0t got outs=%h smp_ready=%b wr_ready=%b expected all 0",
                         $time, observe1(), smp_ready, wr_ready);
            end
            @(negedge clk);
        end
        smp_valid = 1'b0; wr_valid = 1'b0;
        reset = 1'b1;
        m_count = 0; m_wait = 0; m_burst = 0; m_cnt = 0;
        m_a0 = '0; m_a1 = '0; m_d0 = '0; m_d1 = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        n_vec++;
        if (busy !== 1'b0 || cnt_issued !== 16'd0) begin
            n_err++;
            $display("FAIL reset_idle got busy=%b cnt=%0d expected busy=0 cnt=0", busy, cnt_issued);
        end
    endtask

    task automatic test_single_write();
        int k;
        do_reset();
        step(1'b0, 8'd0, 8'd0, 1'b1, 3'd1, 8'd5);
        k = 0;
        for (int i = 1; i <= 8 && k == 0; i++) begin
            idle();
            if (updateWeight === 1'b1) k = i;
        end
        n_vec++;
        if (k != 3 || dualUpdateWeights !== 1'b0 || Addr1 !== 3'd1 || Data1 !== 8'd5) begin
            n_err++;
            $display("FAIL single_write got edge=%0d dual=%b addr1=%0d data1=%0d expected edge=3 dual=0 addr1=1 data1=5",
                     k, dualUpdateWeights, Addr1, Data1);
        end
        idle();
        n_vec++;
        if (updateWeight !== 1'b0) begin
            n_err++;
            $display("FAIL single_one_cycle got updateWeight=%b expected 0", updateWeight);
        end
    endtask

    task automatic test_pair();
        int k;
        do_reset();
        step(1'b0, 8'd0, 8'd0, 1'b1, 3'd1, 8'd5);
        step(1'b0, 8'd0, 8'd0, 1'b1, 3'd2, 8'd6);
        k = 0;
        for (int i = 1; i <= 6 && k == 0; i++) begin
            idle();
            if (updateWeight === 1'b1) k = i;
        end
        n_vec++;
        if (k != 1 || {dualUpdateWeights, Addr1, Data1, Addr2, Data2} !== {1'b1, 3'd1, 8'd5, 3'd2, 8'd6}) begin
            n_err++;
            $display("FAIL pair got edge=%0d dual=%b a1=%0d d1=%0d a2=%0d d2=%0d expected edge=1 dual=1 a1=1 d1=5 a2=2 d2=6",
                     k, dualUpdateWeights, Addr1, Data1, Addr2, Data2);
        end
        idle();
        n_vec++;
        if (updateWeight !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL pair_done got updateWeight=%b busy=%b expected 0 0", updateWeight, busy);
        end
    endtask

    task automatic test_merge();
        int k;
        do_reset();
        step(1'b0, 8'd0, 8'd0, 1'b1, 3'd3, 8'd7);
        step(1'b0, 8'd0, 8'd0, 1'b1, 3'd3, 8'd9);
        k = 0;
        for (int i = 1; i <= 6 && k == 0; i++) begin
            idle();
            if (updateWeight === 1'b1) k = i;
        end
        n_vec++;
        if (k != 2 || dualUpdateWeights !== 1'b0 || Addr1 !== 3'd3 || Data1 !== 8'd9) begin
            n_err++;
            $display("FAIL merge got edge=%0d dual=%b addr1=%0d data1=%0d expected edge=2 dual=0 addr1=3 data1=9",
                     k, dualUpdateWeights, Addr1, Data1);
        end
    endtask

    task automatic test_sample();
        do_reset();
        n_vec++;
        if (cnt_issued !== 16'd0) begin
            n_err++;
            $display("FAIL sample_pre got cnt=%0d expected 0", cnt_issued);
        end
        step(1'b1, 8'd10, 8'd10, 1'b0, 3'd0, 8'd0);
        n_vec++;
        if ({countSteps, updateWeight, A, B, cnt_issued} !== {1'b1, 1'b0, 8'd10, 8'd10, 16'd1}) begin
            n_err++;
            $display("FAIL sample got cs=%b uw=%b A=%0d B=%0d cnt=%0d expected cs=1 uw=0 A=10 B=10 cnt=1",
                     countSteps, updateWeight, A, B, cnt_issued);
        end
    endtask

    // PAIR_WAIT=0 instance: writes every cycle with a sample held pending.
    task automatic test_burst();
        logic [1:0] want [6];
        want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b01;
        want[3] = 2'b01; want[4] = 2'b10; want[5] = 2'b01;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'd30, 8'd30, 1'b1, 3'(i), 8'(i + 1));
            n_vec++;
            if ({u2_cs, u2_uw} !== want[i] || (want[i] == 2'b10 && {u2_a, u2_b} !== {8'd30, 8'd30})) begin
                n_err++;
                $display("FAIL burst[%0d] got cs/uw=%b A=%0d B=%0d expected cs/uw=%b A=30 B=30",
                         i, {u2_cs, u2_uw}, u2_a, u2_b, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b0, 8'd0, 8'd0, 1'b1, 3'd4, 8'd8);
        idle();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle();
            n_vec++;
            if (updateWeight !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_upd[%0d] got updateWeight=%b expected 0", i, updateWeight);
            end
        end
        n_vec++;
        if (busy !== 1'b0 || cnt_issued !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid_end got busy=%b cnt=%0d expected 0 0", busy, cnt_issued);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 8'($urandom));
        end
        idle();
        sb_check();
    endtask

    initial begin
        reset = 1'b0;
        smp_valid = 1'b0; smp_a = '0; smp_b = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        m_count = 0; m_wait = 0; m_burst = 0; m_cnt = 0;
        m_a0 = '0; m_a1 = '0; m_d0 = '0; m_d1 = '0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_pair();
        test_merge();
        test_sample();
        test_burst();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
